sigma_delta_1bit_dac: RTL and testbench

Single-bit sigma-delta audio DAC. It converts a 20-bit unsigned (offset-binary) PCM sample into a 1-bit pulse-density stream for an external RC filter. One instance is used per audio channel. The audio path feeds it the value {1'b0, sample16 (sign-adjusted), 3'b000}, and its output drives the board PWM audio pin. The modulator is first or second order, selected by parameter, and its integrators saturate.

---
 rtl/sigma_delta_1bit_dac.sv | 99 +++++++++
 tb/tb_sigma_delta_1bit_dac.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_1bit_dac.sv
// Single-bit sigma-delta DAC with saturating integrators.
// Converts an unsigned offset-binary PCM sample into a 1-bit pulse-density
// stream. First or second order, chosen by the ORDER parameter.
module sigma_delta_1bit_dac #(
  parameter int unsigned W     = 20,
  parameter int unsigned ORDER = 2,
  parameter int unsigned AW    = W + 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_ena,
  input  logic [W-1:0] pcm_in,
  output logic         dac_out
);

  // Sums are formed two bits wider than the integrators so that
  // acc + x - fb can never wrap before it is clamped.
  localparam int unsigned SW = AW + 2;

  // Feedback level for a registered '1': exactly 2^W.
  localparam logic signed [SW-1:0] FbHi   = {{(SW-W-1){1'b0}}, 1'b1, {W{1'b0}}};
  // Integrator limits, pre-extended to sum width for direct comparison.
  localparam logic signed [SW-1:0] SatMax = {3'b000, {(AW-1){1'b1}}};
  localparam logic signed [SW-1:0] SatMin = {3'b111, {(AW-1){1'b0}}};

  // Elaboration-time parameter checks.
  if ((ORDER != 1) && (ORDER != 2)) begin : g_bad_order
    $error("sigma_delta_1bit_dac: ORDER must be 1 or 2");
  end
  if (AW < W + 1) begin : g_bad_aw
    $error("sigma_delta_1bit_dac: AW must be at least W+1");
  end

  // Sign-extend an integrator value to sum width.
  function automatic logic signed [SW-1:0] sext(input logic signed [AW-1:0] v);
    return {{2{v[AW-1]}}, v};
  endfunction

  // Clamp a wide sum into the signed integrator range; never wraps.
  function automatic logic signed [AW-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [AW-1:0] r;
    if (v > SatMax) begin
      r = SatMax[AW-1:0];
    end else if (v < SatMin) begin
      r = SatMin[AW-1:0];
    end else begin
      r = v[AW-1:0];
    end
    return r;
  endfunction

  logic signed [AW-1:0] r_acc1;
  logic signed [AW-1:0] r_acc2;
  logic                 r_dac_out;

  logic signed [SW-1:0] w_x;
  logic signed [SW-1:0] w_fb;
  logic signed [SW-1:0] w_s1;
  logic signed [AW-1:0] w_acc1_n;
  logic signed [AW-1:0] w_acc2_n;
  logic                 w_bit_n;

  // Input is used directly on the enabled edge; no input register.
  assign w_x  = $signed({{(SW-W){1'b0}}, pcm_in});
  // Feedback comes from the currently registered output bit.
  assign w_fb = r_dac_out ? FbHi : '0;

  // First integrator: common to both orders.
  assign w_s1     = sext(r_acc1) + w_x - w_fb;
  assign w_acc1_n = sat(w_s1);

  if (ORDER == 2) begin : g_order2
    logic signed [SW-1:0] w_s2;
    // Second integrator accumulates the freshly updated first stage.
    assign w_s2     = sext(r_acc2) + sext(w_acc1_n) - w_fb;
    assign w_acc2_n = sat(w_s2);
    assign w_bit_n  = (w_acc2_n > 0);
  end else begin : g_order1
    // Second integrator unused: held at zero.
    assign w_acc2_n = '0;
    assign w_bit_n  = (w_acc1_n > 0);
  end

  // Modulator state: advances only on enabled edges, clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc1    <= '0;
      r_acc2    <= '0;
      r_dac_out <= 1'b0;
    end else if (clk_ena) begin
      r_acc1    <= w_acc1_n;
      r_acc2    <= w_acc2_n;
      r_dac_out <= w_bit_n;
    end
  end

  assign dac_out = r_dac_out;

endmodule

// File: tb/tb_sigma_delta_1bit_dac.sv
// Self-checking bench for sigma_delta_1bit_dac: three instances (order 1,
// order 2, order 2 with narrow integrators to force saturation) share one
// stimulus and are checked every cycle against an arithmetic model.
module tb_sigma_delta_1bit_dac;

  localparam int W    = 20;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_ena;
  logic [W-1:0]  pcm_in;
  logic          w_o1;
  logic          w_o2;
  logic          w_os;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state per instance: 0 = order 1, 1 = order 2, 2 = order 2 / AW 21.
  longint m_acc1 [3];
  longint m_acc2 [3];
  bit     m_out  [3];
  int     ord    [3] = '{1, 2, 2};
  int     awv    [3] = '{W + 4, W + 4, W + 1};

  sigma_delta_1bit_dac #(.W(W), .ORDER(1)) u_o1 (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .pcm_in(pcm_in), .dac_out(w_o1)
  );
  sigma_delta_1bit_dac #(.W(W), .ORDER(2)) u_o2 (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .pcm_in(pcm_in), .dac_out(w_o2)
  );
  sigma_delta_1bit_dac #(.W(W), .ORDER(2), .AW(W + 1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .pcm_in(pcm_in), .dac_out(w_os)
  );

  always #5 clk = ~clk;

  function automatic longint sat(longint v, int aw);
    longint mx = (longint'(1) << (aw - 1)) - 1;
    longint mn = -(longint'(1) << (aw - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic bit dut_out(int k);
    case (k)
      0:       return w_o1;
      1:       return w_o2;
      default: return w_os;
    endcase
  endfunction

  function automatic longint dut_acc1(int k);
    case (k)
      0:       return longint'(u_o1.r_acc1);
      1:       return longint'(u_o2.r_acc1);
      default: return longint'(u_sat.r_acc1);
    endcase
  endfunction

  function automatic longint dut_acc2(int k);
    case (k)
      0:       return longint'(u_o1.r_acc2);
      1:       return longint'(u_o2.r_acc2);
      default: return longint'(u_sat.r_acc2);
    endcase
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(string name, longint act, longint lo, longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_acc1[k] = 0;
      m_acc2[k] = 0;
      m_out[k]  = 1'b0;
    end
  endtask

  // One enabled modulator step, straight from the arithmetic definition.
  task automatic model_step(bit ena, logic [W-1:0] x);
    longint fb, a1, a2;
    if (!ena) return;
    for (int k = 0; k < 3; k++) begin
      fb = m_out[k] ? longint'(FULL) : 0;
      a1 = sat(m_acc1[k] + longint'(x) - fb, awv[k]);
      if (ord[k] == 2) begin
        a2 = sat(m_acc2[k] + a1 - fb, awv[k]);
        m_out[k] = (a2 > 0);
      end else begin
        a2 = 0;
        m_out[k] = (a1 > 0);
      end
      m_acc1[k] = a1;
      m_acc2[k] = a2;
    end
  endtask

  // Compare process: DUT against model every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("dac_out[%0d]", k), longint'(dut_out(k)), longint'(m_out[k]));
        check($sformatf("acc1[%0d]", k), dut_acc1(k), m_acc1[k]);
        check($sformatf("acc2[%0d]", k), dut_acc2(k), m_acc2[k]);
      end
    end
  end

  // Drive one clock: inputs set in the low phase, model stepped after the edge.
  task automatic cyc(bit ena, logic [W-1:0] x);
    clk_ena = ena;
    pcm_in  = x;
    @(posedge clk);
    #1;
    if (rst_n) model_step(ena, x);
    @(negedge clk);
  endtask

  // Reset with the clock running and a nonzero input; release at a falling edge.
  task automatic do_reset(int n);
    #2;
    rst_n = 1'b0;
    model_reset();
    clk_ena = 1'b1;
    pcm_in  = W'(HALF);
    repeat (n) @(negedge clk);
    check("reset_out_o1", longint'(w_o1), 0);
    check("reset_out_o2", longint'(w_o2), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int ones [3];
    bit seq1 [6];
    bit seq2 [6];
    bit exp1 [6] = '{1, 0, 1, 0, 1, 0};
    bit exp2 [6] = '{1, 0, 0, 1, 1, 0};
    bit en;
    logic [W-1:0] x;

    rst_n   = 1'b1;
    clk_ena = 1'b0;
    pcm_in  = '0;
    model_reset();
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;

    // Reset release and half-scale patterns.
    do_reset(4);
    ones = '{0, 0, 0};
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b1, W'(HALF));
      if (i < 6) begin
        seq1[i] = w_o1;
        seq2[i] = w_o2;
      end
      ones[0] += int'(w_o1);
      ones[1] += int'(w_o2);
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("half_o1_seq%0d", i), longint'(seq1[i]), longint'(exp1[i]));
      check($sformatf("half_o2_seq%0d", i), longint'(seq2[i]), longint'(exp2[i]));
    end
    check_range("half_o1_density", ones[0], 510, 514);
    check_range("half_o2_density", ones[1], 509, 515);

    // Zero input gives a constant zero stream.
    do_reset(2);
    ones = '{0, 0, 0};
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, '0);
      ones[0] += int'(w_o1);
      ones[1] += int'(w_o2);
    end
    check("zero_o1_ones", ones[0], 0);
    check("zero_o2_ones", ones[1], 0);

    // Quarter scale, enabled every fourth clock.
    do_reset(2);
    ones = '{0, 0, 0};
    for (int i = 0; i < 4096; i++) begin
      en = (i % 4 == 0);
      cyc(en, W'(HALF / 2));
      if (en) begin
        ones[0] += int'(w_o1);
        ones[1] += int'(w_o2);
      end
    end
    check_range("gate_o1_density", ones[0], 254, 258);
    check_range("gate_o2_density", ones[1], 253, 259);

    // Overdrive at full code, then unwind with zero input.
    do_reset(2);
    ones = '{0, 0, 0};
    for (int i = 0; i < 10000; i++) begin
      cyc(1'b1, {W{1'b1}});
      ones[0] += int'(w_o1);
      ones[1] += int'(w_o2);
    end
    check_range("over_o1_density", ones[0], 9500, 10000);
    check_range("over_o2_density", ones[1], 9500, 10000);
    ones = '{0, 0, 0};
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, '0);
      if (i >= 64) begin
        ones[0] += int'(w_o1);
        ones[1] += int'(w_o2);
      end
    end
    check("unwind_o1_ones", ones[0], 0);
    check("unwind_o2_ones", ones[1], 0);

    // Random inputs, random enables, occasional asynchronous mid-stream resets.
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       x = W'($urandom);
        1:       x = W'($urandom_range(0, HALF));
        2:       x = (i % 2 == 0) ? {W{1'b1}} : W'($urandom_range(FULL - 4096, FULL - 1));
        default: x = W'($urandom_range(0, 4096));
      endcase
      en = ($urandom_range(0, 3) != 0);
      cyc(en, x);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_o1", longint'(w_o1), 0);
        check("async_rst_o2", longint'(w_o2), 0);
        check("async_rst_os", longint'(w_os), 0);
        repeat ($urandom_range(1, 3)) cyc(1'b1, W'($urandom));
        rst_n = 1'b1;
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
